// File: rtl/packing_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : packing_stream_if
//  Description : Stream bundle for the serial-to-parallel packer. Carries the
//                narrow input stream (data_i/valid_i/last_i/ready_o) and the
//                wide packed output stream (data_o/valid_o/last_o/count_o/
//                ready_i).
//                slave  : packer side (consumes samples, produces words)
//                master : environment side (produces samples, consumes words)
//                Optional macro PACKING_STREAM_SHORT_ERR_EN adds short_err_o.
//  Revision    : 1.0 - initial release
// ============================================================================
interface packing_stream_if #(
    parameter int I_BW   = 8,
    parameter int N_ELEM = 13
);
    localparam int O_BW   = I_BW * N_ELEM;
    localparam int CNT_BW = $clog2(N_ELEM + 1);

    // Samples are signed but packed bit-for-bit, so no arithmetic is applied.
    logic [I_BW-1:0]   data_i;
    logic              valid_i;
    logic              last_i;
    logic              ready_o;
    logic [O_BW-1:0]   data_o;
    logic              valid_o;
    logic              last_o;
    logic [CNT_BW-1:0] count_o;
    logic              ready_i;
`ifdef PACKING_STREAM_SHORT_ERR_EN
    logic              short_err_o;
`endif

    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, last_o, count_o
`ifdef PACKING_STREAM_SHORT_ERR_EN
        , output short_err_o
`endif
    );

    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, count_o
`ifdef PACKING_STREAM_SHORT_ERR_EN
        , input short_err_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/packing_stream.sv
`default_nettype none
// ============================================================================
//  Module      : packing_stream
//  Description : Collects N_ELEM samples of I_BW bits from a valid/ready
//                stream and emits them as one N_ELEM*I_BW-bit word. A frame
//                may end early on last_i; unwritten slots are zero padded.
//                MSB_FIRST=1 puts the first sample in the top bits.
//  Ports       : clk_i    - clock, rising edge
//                rst_n_i  - synchronous active-low reset
//                en_i     - enable, low acts as synchronous clear
//                s        - packing_stream_if.slave stream bundle
//  Options     : PACKING_STREAM_SHORT_ERR_EN adds s.short_err_o, set for a
//                word closed by last_i with fewer than N_ELEM samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module packing_stream #(
    parameter int I_BW      = 8,
    parameter int N_ELEM    = 13,
    parameter int MSB_FIRST = 1
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n_i,
    input  wire logic          en_i,
    packing_stream_if.slave    s
);
    localparam int O_BW   = I_BW * N_ELEM;
    localparam int CNT_BW = $clog2(N_ELEM + 1);
    localparam logic [CNT_BW-1:0] C_LAST_SLOT = CNT_BW'(N_ELEM - 1);

    logic [CNT_BW-1:0] r_cnt;
    logic [O_BW-1:0]   r_slots;
    logic [O_BW-1:0]   r_data;
    logic              r_valid;
    logic              r_last;
    logic [CNT_BW-1:0] r_count;
    logic              r_short;

    logic              w_ready;
    logic              w_accept;
    logic              w_complete;
    logic [O_BW-1:0]   w_merged;

    // Output stage is free when empty or being drained this cycle. Reset is
    // folded in so the input is never offered while the block is cleared.
    assign w_ready    = en_i & rst_n_i & (~r_valid | s.ready_i);
    assign w_accept   = s.valid_i & w_ready;
    assign w_complete = (r_cnt == C_LAST_SLOT) | s.last_i;

    // Assembly contents with the current sample dropped into slot r_cnt.
    // Completed words load from here, so the closing sample needs no extra
    // cycle in the assembly register.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            always_comb begin
                w_merged = r_slots;
                for (int k = 0; k < N_ELEM; k++) begin
                    if (r_cnt == CNT_BW'(k)) begin
                        w_merged[O_BW-1-k*I_BW -: I_BW] = s.data_i;
                    end
                end
            end
        end else begin : g_lsb_first
            always_comb begin
                w_merged = r_slots;
                for (int k = 0; k < N_ELEM; k++) begin
                    if (r_cnt == CNT_BW'(k)) begin
                        w_merged[k*I_BW +: I_BW] = s.data_i;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !en_i) begin
            r_cnt   <= '0;
            r_slots <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_short <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_cnt   <= '0;
                    r_slots <= '0;
                end else begin
                    r_cnt   <= r_cnt + CNT_BW'(1);
                    r_slots <= w_merged;
                end
            end

            // A completing beat overrides the drain, so a simultaneous
            // transfer and completion keeps valid high with the new word.
            if (w_accept && w_complete) begin
                r_data  <= w_merged;
                r_valid <= 1'b1;
                r_last  <= s.last_i;
                r_count <= r_cnt + CNT_BW'(1);
                r_short <= s.last_i & (r_cnt != C_LAST_SLOT);
            end else if (s.ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign s.ready_o = w_ready;
    assign s.data_o  = r_data;
    assign s.valid_o = r_valid;
    assign s.last_o  = r_last;
    assign s.count_o = r_count;
`ifdef PACKING_STREAM_SHORT_ERR_EN
    assign s.short_err_o = r_short;
`else
    logic w_unused;
    assign w_unused = r_short;
`endif
endmodule
`default_nettype wire

// File: tb/tb_packing_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packing_stream
//  Description : Self-checking bench for packing_stream. Two instances share
//                the same stimulus, one per element ordering. A queue-based
//                reference model collects accepted samples per frame and
//                packs them arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packing_stream;
    localparam int I_BW   = 8;
    localparam int N_ELEM = 13;
    localparam int O_BW   = I_BW * N_ELEM;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] din = '0;
    logic       valid = 1'b0;
    logic       last = 1'b0;
    logic       rdy = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    packing_stream_if #(.I_BW(I_BW), .N_ELEM(N_ELEM)) if_m ();
    packing_stream_if #(.I_BW(I_BW), .N_ELEM(N_ELEM)) if_l ();

    assign if_m.data_i  = din;
    assign if_m.valid_i = valid;
    assign if_m.last_i  = last;
    assign if_m.ready_i = rdy;
    assign if_l.data_i  = din;
    assign if_l.valid_i = valid;
    assign if_l.last_i  = last;
    assign if_l.ready_i = rdy;

    packing_stream #(.I_BW(I_BW), .N_ELEM(N_ELEM), .MSB_FIRST(1)) u_dut_msb (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .s       (if_m.slave)
    );

    packing_stream #(.I_BW(I_BW), .N_ELEM(N_ELEM), .MSB_FIRST(0)) u_dut_lsb (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .s       (if_l.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: what the outputs should show right now.
    logic [7:0]      part[$];
    logic [O_BW-1:0] m_msb = '0;
    logic [O_BW-1:0] m_lsb = '0;
    logic            m_valid = 1'b0;
    logic            m_last = 1'b0;
    int              m_count = 0;
    logic            m_short = 1'b0;
    logic            m_fresh = 1'b1;
    int              n_xfer = 0;
    beat_t           tx_q[$];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Runs at the falling edge: compares outputs, then advances the model
    // across the coming rising edge.
    task automatic model_step(output bit acc);
        bit exp_ready;
        exp_ready = en && rst_n && (!m_valid || rdy);
        chk("ready_o_msb", 128'(if_m.ready_o), 128'(exp_ready));
        chk("ready_o_lsb", 128'(if_l.ready_o), 128'(exp_ready));
        chk("valid_o_msb", 128'(if_m.valid_o), 128'(m_valid));
        chk("valid_o_lsb", 128'(if_l.valid_o), 128'(m_valid));
        if (m_valid || m_fresh) begin
            chk("data_o_msb",  128'(if_m.data_o),  128'(m_msb));
            chk("data_o_lsb",  128'(if_l.data_o),  128'(m_lsb));
            chk("last_o",      128'(if_m.last_o),  128'(m_last));
            chk("count_o",     128'(if_m.count_o), 128'(m_count));
            chk("count_o_lsb", 128'(if_l.count_o), 128'(m_count));
`ifdef PACKING_STREAM_SHORT_ERR_EN
            chk("short_err_o", 128'(if_m.short_err_o), 128'(m_short));
`endif
        end
        acc = valid && exp_ready;
        if (!rst_n || !en) begin
            part.delete();
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_count = 0;
            m_msb   = '0;
            m_lsb   = '0;
            m_short = 1'b0;
            m_fresh = 1'b1;
        end else begin
            if (m_valid && rdy) begin
                m_valid = 1'b0;
                n_xfer++;
            end
            if (acc) begin
                part.push_back(din);
                if (part.size() == N_ELEM || last) begin
                    m_msb = '0;
                    m_lsb = '0;
                    foreach (part[i]) begin
                        m_msb = m_msb | (O_BW'(part[i]) << ((N_ELEM - 1 - i) * I_BW));
                        m_lsb = m_lsb | (O_BW'(part[i]) << (i * I_BW));
                    end
                    m_valid = 1'b1;
                    m_last  = last;
                    m_count = part.size();
                    m_short = last && (part.size() < N_ELEM);
                    m_fresh = 1'b0;
                    part.delete();
                end
            end
        end
    endtask

    task automatic do_cycle(input logic r, input logic e, input logic v,
                            input logic [7:0] d, input logic l, input logic rd,
                            output bit acc);
        rst_n = r;
        en    = e;
        valid = v;
        din   = d;
        last  = l;
        rdy   = rd;
        @(negedge clk);
        model_step(acc);
        @(posedge clk);
        #1;
    endtask

    // Sends tx_q; optional idle gaps and a ready_i stall starting at the
    // first word that becomes valid.
    task automatic drive_q(input int gap_pct, input int stall_cycles);
        int  budget = 400;
        int  stall_left = 0;
        bit  armed = (stall_cycles > 0);
        bit  v;
        bit  acc;
        while (tx_q.size() > 0 && budget > 0) begin
            if (armed && m_valid) begin
                stall_left = stall_cycles;
                armed = 1'b0;
            end
            v = ($urandom_range(0, 99) >= gap_pct);
            do_cycle(1'b1, 1'b1, v, tx_q[0].d, tx_q[0].l, (stall_left == 0), acc);
            if (stall_left > 0) stall_left--;
            if (acc) void'(tx_q.pop_front());
            budget--;
        end
        chk("drive_budget", 128'(tx_q.size()), 128'(0));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    initial begin
        bit acc;
        int xfer0;
        @(posedge clk);
        #1;

        // Reset
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, acc);
        idle(2);

        // Full frame 0x01..0x0D, last on the final sample
        for (int i = 1; i <= 13; i++) tx_q.push_back('{d: 8'(i), l: (i == 13)});
        drive_q(0, 0);
        chk("full_valid",    128'(if_m.valid_o), 128'(1));
        chk("full_data_msb", 128'(if_m.data_o),  128'(104'h0102030405060708090A0B0C0D));
        chk("full_data_lsb", 128'(if_l.data_o),  128'(104'h0D0C0B0A090807060504030201));
        chk("full_count",    128'(if_m.count_o), 128'(13));
        chk("full_last",     128'(if_m.last_o),  128'(1));
        idle(3);

        // Short frame 0xA1..0xA5
        for (int i = 0; i < 5; i++) tx_q.push_back('{d: 8'(8'hA1 + i), l: (i == 4)});
        drive_q(0, 0);
        chk("short_data_msb", 128'(if_m.data_o),  128'({40'hA1A2A3A4A5, 64'h0}));
        chk("short_data_lsb", 128'(if_l.data_o),  128'(104'hA5A4A3A2A1));
        chk("short_count",    128'(if_m.count_o), 128'(5));
        chk("short_last",     128'(if_m.last_o),  128'(1));
`ifdef PACKING_STREAM_SHORT_ERR_EN
        chk("short_err",      128'(if_m.short_err_o), 128'(1));
`endif
        idle(3);

        // 26 samples with gaps and a 4-cycle stall on the first word
        xfer0 = n_xfer;
        for (int i = 0; i < 26; i++) tx_q.push_back('{d: 8'($urandom), l: 1'b0});
        drive_q(30, 4);
        idle(4);
        chk("gap_words", 128'(n_xfer - xfer0), 128'(2));

        // Enable drop mid-frame discards the partial frame
        for (int i = 0; i < 7; i++) tx_q.push_back('{d: 8'(8'h70 + i), l: 1'b0});
        drive_q(0, 0);
        do_cycle(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, acc);
        xfer0 = n_xfer;
        for (int i = 0; i < 13; i++) tx_q.push_back('{d: 8'(8'h30 + i), l: 1'b0});
        drive_q(0, 0);
        chk("en_count", 128'(if_m.count_o), 128'(13));
        chk("en_data",  128'(if_m.data_o),  128'(104'h303132333435363738393A3B3C));
        idle(3);
        chk("en_words", 128'(n_xfer - xfer0), 128'(1));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            do_cycle(1'b1, ($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
                     8'($urandom), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 9) < 7), acc);
        end
        idle(3);

        // Reset while a word is stalled
        for (int i = 0; i < 13; i++) do_cycle(1'b1, 1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, acc);
        do_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("pre_rst_valid", 128'(if_m.valid_o), 128'(1));
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("rst_valid", 128'(if_m.valid_o), 128'(0));
        chk("rst_count", 128'(if_m.count_o), 128'(0));
        chk("rst_data",  128'(if_m.data_o),  128'(0));
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
